// File: rtl/fft_result_streamer.sv
// fft_result_streamer: captures one N-point complex FFT frame in a cycle and streams it one bin per beat
module fft_result_streamer #(
    parameter int DATA_W = 16,
    parameter int N_PTS  = 16,
    parameter int IDX_W  = $clog2(N_PTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_PTS*DATA_W-1:0] in_re,
    input  logic [N_PTS*DATA_W-1:0] in_im,
    input  logic                    mode_bitrev,
    input  logic                    mode_sm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IDX_W-1:0]        out_idx,
    output logic [DATA_W-1:0]       out_re,
    output logic [DATA_W-1:0]       out_im,
    output logic                    out_re_neg,
    output logic                    out_im_neg,
    output logic                    out_last,
    output logic [7:0]              frame_cnt
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PTS - 1);

    logic [0:0]              state;
    logic [IDX_W-1:0]        rd_cnt;
    logic [IDX_W-1:0]        rev;
    logic [IDX_W-1:0]        addr;
    logic                    bitrev_q;
    logic                    sm_q;
    logic [N_PTS*DATA_W-1:0] buf_re;
    logic [N_PTS*DATA_W-1:0] buf_im;
    logic [DATA_W-1:0]       s_re;
    logic [DATA_W-1:0]       s_im;

    for (genvar i = 0; i < IDX_W; i++) begin : g_rev
        assign rev[i] = rd_cnt[IDX_W-1-i];
    end

    // Control: capture in IDLE, advance the read counter on each accepted beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            frame_cnt <= '0;
            bitrev_q  <= 1'b0;
            sm_q      <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                state    <= STREAM;
                rd_cnt   <= '0;
                bitrev_q <= mode_bitrev;
                sm_q     <= mode_sm;
            end
        end else if (out_ready) begin
            if (rd_cnt == LAST) begin
                state     <= IDLE;
                rd_cnt    <= '0;
                frame_cnt <= frame_cnt + 8'd1;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Frame buffer: loaded whole on capture, deliberately left uncleared by reset
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            buf_re <= in_re;
            buf_im <= in_im;
        end
    end

    // Output decode from registered state only; zeroed whenever no beat is offered
    always_comb begin
        in_ready   = state == IDLE;
        out_valid  = state == STREAM;
        addr       = bitrev_q ? rev : rd_cnt;
        s_re       = buf_re[addr*DATA_W +: DATA_W];
        s_im       = buf_im[addr*DATA_W +: DATA_W];
        out_idx    = out_valid ? rd_cnt : '0;
        out_last   = out_valid && rd_cnt == LAST;
        out_re_neg = out_valid && s_re[DATA_W-1];
        out_im_neg = out_valid && s_im[DATA_W-1];
        out_re     = !out_valid ? '0 : (sm_q && s_re[DATA_W-1]) ? ~s_re + 1'b1 : s_re;
        out_im     = !out_valid ? '0 : (sm_q && s_im[DATA_W-1]) ? ~s_im + 1'b1 : s_im;
    end
endmodule

// File: doc/fft_result_streamer.md
# fft_result_streamer

Parametrised output stage for the FFT core. It captures one complete N-point complex result frame from the core's parallel output buses in a single cycle, then streams it one bin per cycle over a valid/ready interface. Streaming can optionally reorder bit-reversed bins into natural order and convert two's-complement samples to sign-magnitude. It replaces per-bin parallel result wiring, so downstream logic (host readout, magnitude units) sees a narrow stream.

## Interface
- DATA_W, 16: bits per real/imag sample, two's complement on input; 4..32.
- N_PTS, 16: bins per frame; power of two, 4..256.
- IDX_W, $clog2(N_PTS): bin index width.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  frame present on in_re/in_im.
- in_ready  out  1  block can capture a frame.
- in_re  in  N_PTS*DATA_W  real parts; bin k at [k*DATA_W +: DATA_W].
- in_im  in  N_PTS*DATA_W  imag parts, same packing.
- mode_bitrev  in  1  1: input bins are in bit-reversed order, emit in natural order.
- mode_sm  in  1  1: emit sign-magnitude; 0: emit raw two's complement.
- out_valid  out  1  bin present on out_*.
- out_ready  in  1  consumer accepts bin.
- out_idx  out  IDX_W  natural bin index of the current beat.
- out_re, out_im  out  DATA_W each  sample (magnitude if SM, raw otherwise).
- out_re_neg, out_im_neg  out  1 each  sign bit of the original sample (both modes).
- out_last  out  1  high on bin N_PTS-1.
- frame_cnt  out  8  completed frames, wraps 255→0.

## Operation
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_re/in_im into the frame buffer (N_PTS×2×DATA_W regs).
  - Latch mode_bitrev and mode_sm for the whole frame.
  - rd_cnt←0; go to STREAM.
- STREAM:
  - in_ready=0; in_valid is ignored.
  - out_valid=1, out_idx=rd_cnt.
  - Buffer address = bitrev_IDX_W(rd_cnt) if latched bitrev is set, else rd_cnt.
- Beat handshake (out_valid&&out_ready):
  - rd_cnt<N_PTS-1: rd_cnt+1.
  - rd_cnt=N_PTS-1: frame_cnt+1, go to IDLE.
- Sign-magnitude conversion: neg = sample[DATA_W-1]; magnitude = neg ? (~sample+1) : sample, kept at DATA_W bits unsigned. Most-negative input 2^(DATA_W-1) gives magnitude 2^(DATA_W-1) with neg=1; no saturation.
- Raw mode: out_re/out_im = stored sample; neg flags still equal the sign bit.
- When out_valid=0: out_idx, out_re, out_im, neg flags and out_last are all 0.
- mode_* pins changing during STREAM have no effect until the next capture.

## Timing
- Reset (async, immediate): state=IDLE, rd_cnt=0, frame_cnt=0, out_valid=0, all out_* data=0, in_ready=1. Buffer contents are not cleared.
- No combinational path from in_* or out_ready to any output. All outputs decode from registers only.
- Capture at edge T. out_valid is high from T until the edge after the final handshake; bin 0 is visible in cycle T+1.
- Minimum frame period is N_PTS+1 cycles: N_PTS beats plus one IDLE capture cycle. in_ready rises the cycle after the last beat.
- Backpressure: with out_valid=1 and out_ready=0, all out_* hold stable with no limit on stall length.
- Reset deasserted mid-STREAM: outputs at reset values. The first frame after release starts at out_idx 0; frame_cnt is not incremented for the aborted frame.

## Test plan
- Reset values: assert reset mid-cycle → out_valid=0, in_ready=1, frame_cnt=0, out data 0 with no clock edge needed.
- Natural order, SM mode, N=16, W=16, re_k=k-8, im_k=-k, out_ready=1 →
  - 16 consecutive beats, idx 0..15.
  - idx 3: out_re=5, re_neg=1, out_im=3, im_neg=1.
  - out_last only on idx 15; frame_cnt=1; in_ready high on the 17th cycle.
- Most negative value: re_0=0x8000, im_0=0x7FFF →
  - SM mode: out_re=0x8000, re_neg=1, out_im=0x7FFF, im_neg=0.
  - Raw mode: out_re=0x8000, re_neg=1.
- Bit-reverse, N=16: input position p holds re=p →
  - Beat idx 1 shows re=8; idx 3 shows 12; idx 15 shows 15.
  - mode_bitrev dropped mid-frame has no effect.
- Backpressure: out_ready low for 5 cycles at idx 7, in_valid held high with a new frame →
  - idx/data stable at idx 7; in_ready=0; new frame not captured.
  - Streaming resumes at idx 7 when out_ready returns.
- Reset at idx 9 → out_valid drops immediately. After release a new frame streams from idx 0, and frame_cnt ends at 1 after it completes.
